disp_scan_ctrl: RTL and testbench
=================================

# disp_scan_ctrl

Multiplexed display scan controller that time-shares one BCD-to-seven-segment encoder across `N_DIGITS` common-cathode digits. It double-buffers the digit values, steps through the digits at a fixed slot rate, and inserts an anti-ghosting blank interval before each digit. It can also suppress leading zeros. The block sits between the datapath that produces the values and the encoder input bus, with the digit-enable lines going to the display.

## Interface
- `N_DIGITS`, 4: number of digits scanned; must be ≥2.
- `DIV`, 1000: clock cycles per digit slot; must be > `BLANK_CYCLES`.
- `BLANK_CYCLES`, 2: cycles at the start of each slot with all digits off; must be ≥1.

Ports (clock and reset first):
- `clk`  in  1  the only clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `load`  in  1  single-cycle strobe that captures `data_in` into the shadow buffer.
- `data_in`  in  4*N_DIGITS  digit values; nibble k is digit k, with digit 0 least significant; value 15 means blank.
- `lz_blank`  in  1  leading-zero suppression enable; level-sensitive and sampled every cycle.
- `code`  out  4  encoder input code: 0 = blank, v+1 = digit value v (0..14).
- `an`  out  N_DIGITS  one-hot digit enable, active-high; all zeros when no digit is lit.
- `pending`  out  1  shadow buffer holds data not yet committed.
- `frame_tick`  out  1  one-cycle pulse during the last cycle of each frame.

## Operation
- State:
  - slot counter `cnt`, range 0..DIV-1;
  - digit index `idx`, range 0..N_DIGITS-1;
  - `active` and `shadow` buffers, each 4*N_DIGITS bits;
  - `pending` flag.
- Two-phase slot FSM, decoded from `cnt`:
  - BLANK while `cnt` < `BLANK_CYCLES`.
  - SHOW while `cnt` ≥ `BLANK_CYCLES`.
- `cnt` increments every cycle. At `DIV-1` it wraps to 0 and `idx` advances. `idx` wraps from N_DIGITS-1 to 0.
- In BLANK: `an`=0 and `code`=0.
- In SHOW:
  - `an` = one-hot(`idx`).
  - `code` = 0 if the digit value is 15 or the digit is leading-zero-suppressed; otherwise the digit value + 1.
- Leading-zero suppression (`lz_blank`=1): digit k is suppressed when `active` digits N_DIGITS-1 down to k are all 0 or 15. Digit 0 is never suppressed; a value of 0 on digit 0 displays as code 1.
- `load`=1: `shadow` ← `data_in` and `pending` ← 1 on that edge. Back-to-back loads overwrite; the last one wins.
- Commit happens on the frame-wrap edge (`idx`=N_DIGITS-1 and `cnt`=DIV-1) if `pending`=1:
  - `active` ← `shadow`, using the shadow value from before that edge;
  - `pending` ← 0, unless `load` is also 1 on the same edge, in which case `shadow` takes the new data and `pending` stays 1.
- Effect of the commit rule: `active` never changes mid-frame, so there is no tearing.

## Timing
- Reset values:
  - `cnt`=0, `idx`=0;
  - `active` and `shadow` all 4'hF (all blank);
  - `pending`=0, `code`=0, `an`=0, `frame_tick`=0.
- Reset is asynchronous and takes effect immediately. Asserting it mid-slot or mid-commit discards shadow and active contents.
- All outputs are decoded from registered state only; there is no combinational path from `load`, `data_in` or `lz_blank` to any output except through registers.
  - Exception: `lz_blank` affects `code` through a combinational decode of `active`. This path is allowed, but no glitch may appear on `an`.
- After reset release, `an` first goes nonzero (0001) after `BLANK_CYCLES` rising edges. It stays 0001 for `DIV-BLANK_CYCLES` cycles.
- Frame period is N_DIGITS×DIV cycles. `frame_tick` is high exactly in the cycle where `idx`=N_DIGITS-1 and `cnt`=DIV-1.
- Load-to-display latency:
  - committed on the next frame-wrap edge;
  - digit 0 shows the new value `BLANK_CYCLES` cycles after that edge;
  - worst case ≈ N_DIGITS×DIV + BLANK_CYCLES cycles after `load`.
- `pending` rises on the edge after the `load` cycle and falls on the commit edge.

## Test plan
All scenarios use N_DIGITS=4, DIV=8, BLANK_CYCLES=2.

1. Reset release with no load:
   - `an` toggles 0000→0001 after 2 edges, with `code`=0 (blank) throughout.
   - `an` sequence is 0001, 0010, 0100, 1000, each on for 6 cycles and off for 2.
   - `frame_tick` pulses every 32 cycles.
2. `load` with `data_in`=16'h4321 mid-frame:
   - `pending`=1 until the frame wrap;
   - next frame shows codes 2, 3, 4, 5 on `an`=0001, 0010, 0100, 1000;
   - `pending`=0 after the wrap.
3. `load` of 16'h0000, then 16'h0005 three cycles later in the same frame: only 0005 is displayed next frame, with codes 6, 1, 1, 1.
4. `lz_blank`=1 with `active`=16'h0070:
   - codes are digit0=1, digit1=8, digit2=0, digit3=0;
   - with `active`=16'h0000, only digit 0 shows code 1.
5. `load` asserted exactly on the `frame_tick` cycle:
   - the previous shadow is committed;
   - `pending` stays 1;
   - the new data is committed one frame later.
6. `rst_n` asserted low during SHOW of digit 2 with a pending load: `an`=0 and `code`=0 immediately, `pending`=0, and the display is blank after release.

Source files
------------

// File: rtl/disp_scan_if.sv
// Bus between the value-producing datapath and the display scan controller.
// The master side supplies digit values; the slave side drives the encoder code and digit enables.
interface disp_scan_if #(
    parameter int N_DIGITS = 4
);
    logic                    load;
    logic [4*N_DIGITS-1:0]   data_in;
    logic                    lz_blank;
    logic [3:0]              code;
    logic [N_DIGITS-1:0]     an;
    logic                    pending;
    logic                    frame_tick;

    modport master (
        output load, data_in, lz_blank,
        input  code, an, pending, frame_tick
    );

    modport slave (
        input  load, data_in, lz_blank,
        output code, an, pending, frame_tick
    );
endinterface

// File: rtl/disp_scan_ctrl.sv
// Multiplexed seven-segment scan controller: double-buffered digit values, per-slot blanking,
// frame-aligned commit of new values and optional leading-zero suppression.
module disp_scan_ctrl #(
    parameter int N_DIGITS     = 4,
    parameter int DIV          = 1000,
    parameter int BLANK_CYCLES = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    disp_scan_if.slave   bus
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW = $clog2(N_DIGITS);
    localparam int DW = 4 * N_DIGITS;
    localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] CNT_SHOW = CW'(BLANK_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(N_DIGITS - 1);

    typedef enum logic {PH_BLANK, PH_SHOW} phase_t;

    logic [CW-1:0]       cnt_reg, cnt_next;
    logic [IW-1:0]       idx_reg, idx_next;
    logic [DW-1:0]       active_reg, shadow_reg;
    logic                pending_reg;
    logic [N_DIGITS-1:0] an_reg;
    logic                frame_tick_reg;
    phase_t              phase_reg;

    logic                cnt_wrap, frame_wrap;
    logic [N_DIGITS-1:0] onehot_next;
    logic [3:0]          nib [N_DIGITS];
    logic [N_DIGITS-1:0] zero_or_blank;
    logic [N_DIGITS-1:0] suppress;
    logic                run;
    logic [3:0]          cur_digit;
    logic                cur_hidden;

    assign cnt_wrap   = (cnt_reg == CNT_LAST);
    assign frame_wrap = cnt_wrap && (idx_reg == IDX_LAST);

    always_comb begin
        cnt_next = cnt_reg + 1'b1;
        idx_next = idx_reg;
        if (cnt_wrap) begin
            cnt_next = '0;
            idx_next = (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            assign onehot_next[gi]   = (idx_next == IW'(gi));
            assign nib[gi]           = active_reg[gi*4 +: 4];
            assign zero_or_blank[gi] = (nib[gi] == 4'h0) || (nib[gi] == 4'hF);
        end
    endgenerate

    // A digit is suppressed when it and every more significant digit is zero or blank;
    // digit 0 always stays visible so a zero value still reads as "0".
    always_comb begin
        run      = 1'b1;
        suppress = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            run         = run & zero_or_blank[k];
            suppress[k] = run & (k != 0);
        end
    end

    assign cur_digit  = nib[idx_reg];
    assign cur_hidden = (cur_digit == 4'hF) || (bus.lz_blank && suppress[idx_reg]);

    // Enables and phase are registered from the next-state values so an never glitches;
    // only code keeps a live path from lz_blank.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_reg        <= '0;
            idx_reg        <= '0;
            active_reg     <= {DW{1'b1}};
            shadow_reg     <= {DW{1'b1}};
            pending_reg    <= 1'b0;
            an_reg         <= '0;
            frame_tick_reg <= 1'b0;
            phase_reg      <= PH_BLANK;
        end else begin
            cnt_reg        <= cnt_next;
            idx_reg        <= idx_next;
            phase_reg      <= (cnt_next >= CNT_SHOW) ? PH_SHOW : PH_BLANK;
            an_reg         <= (cnt_next >= CNT_SHOW) ? onehot_next : '0;
            frame_tick_reg <= (cnt_next == CNT_LAST) && (idx_next == IDX_LAST);
            if (frame_wrap && pending_reg)
                active_reg <= shadow_reg;
            if (bus.load) begin
                shadow_reg  <= bus.data_in;
                pending_reg <= 1'b1;
            end else if (frame_wrap) begin
                pending_reg <= 1'b0;
            end
        end
    end

    assign bus.code       = (phase_reg == PH_SHOW && !cur_hidden) ? cur_digit + 4'd1 : 4'd0;
    assign bus.an         = an_reg;
    assign bus.pending    = pending_reg;
    assign bus.frame_tick = frame_tick_reg;
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Bench for disp_scan_ctrl: a frame-position model checked every cycle plus directed scenarios
// with literal expectations.
module tb_disp_scan_ctrl;
    localparam int N     = 4;
    localparam int DIV   = 8;
    localparam int BL    = 2;
    localparam int FRAME = N * DIV;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    disp_scan_if #(.N_DIGITS(N)) bus ();

    disp_scan_ctrl #(.N_DIGITS(N), .DIV(DIV), .BLANK_CYCLES(BL)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: edges since reset release plus the double buffer; position within the frame
    // is plain arithmetic on the edge count.
    int          n_m;
    logic [15:0] act_m, shd_m;
    logic        pend_m;

    function automatic bit at_wrap(input int n);
        return (n % FRAME) == FRAME - 1;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_m    <= 0;
            act_m  <= 16'hFFFF;
            shd_m  <= 16'hFFFF;
            pend_m <= 1'b0;
        end else begin
            if (at_wrap(n_m) && pend_m)
                act_m <= shd_m;
            if (bus.load) begin
                shd_m  <= bus.data_in;
                pend_m <= 1'b1;
            end else if (at_wrap(n_m)) begin
                pend_m <= 1'b0;
            end
            n_m <= n_m + 1;
        end
    end

    function automatic logic [3:0] model_code(input int d, input logic [15:0] act, input logic lz);
        logic [3:0] v;
        bit         supp;
        v = act[4*d +: 4];
        if (v == 4'hF) return 4'd0;
        if (lz && d != 0) begin
            supp = 1'b1;
            for (int j = d; j < N; j++)
                if (act[4*j +: 4] != 4'h0 && act[4*j +: 4] != 4'hF) supp = 1'b0;
            if (supp) return 4'd0;
        end
        return v + 4'd1;
    endfunction

    int         cp_p, cp_d;
    bit         cp_show;
    logic [3:0] cp_an, cp_code;

    initial forever begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            cp_p    = n_m % FRAME;
            cp_d    = cp_p / DIV;
            cp_show = (cp_p % DIV) >= BL;
            cp_an   = cp_show ? 4'(1 << cp_d) : 4'h0;
            cp_code = cp_show ? model_code(cp_d, act_m, bus.lz_blank) : 4'h0;
            check("model_an",         16'(bus.an),         16'(cp_an));
            check("model_code",       16'(bus.code),       16'(cp_code));
            check("model_pending",    16'(bus.pending),    16'(pend_m));
            check("model_frame_tick", 16'(bus.frame_tick), 16'(cp_p == FRAME - 1));
        end
    end

    task automatic cyc1();
        @(negedge clk);
        #2;
    endtask

    task automatic do_load(input logic [15:0] v);
        bus.load    = 1'b1;
        bus.data_in = v;
        cyc1();
        bus.load    = 1'b0;
    endtask

    task automatic wait_tick(output int waited);
        bit found;
        found  = 1'b0;
        waited = 0;
        while (!found && waited < 100) begin
            cyc1();
            waited++;
            if (bus.frame_tick) found = 1'b1;
        end
        if (!found) check("tick_timeout", 16'h0, 16'h1);
    endtask

    task automatic wait_an(input logic [3:0] v);
        bit found;
        int n;
        found = 1'b0;
        n     = 0;
        while (!found && n < 64) begin
            cyc1();
            n++;
            if (bus.an == v) found = 1'b1;
        end
        if (!found) check("an_timeout", 16'(bus.an), 16'(v));
    endtask

    task automatic scan_frame(input string name, input logic [3:0] c0, input logic [3:0] c1,
                              input logic [3:0] c2, input logic [3:0] c3);
        logic [3:0] exp [4];
        exp = '{c0, c1, c2, c3};
        for (int k = 0; k < N; k++) begin
            wait_an(4'(1 << k));
            check(name, 16'(bus.code), 16'(exp[k]));
        end
    endtask

    int w;

    initial begin
        bus.load     = 1'b0;
        bus.data_in  = 16'h0000;
        bus.lz_blank = 1'b0;

        // reset values
        repeat (3) @(negedge clk);
        #2;
        check("rst_an",         16'(bus.an),         16'h0);
        check("rst_code",       16'(bus.code),       16'h0);
        check("rst_pending",    16'(bus.pending),    16'h0);
        check("rst_frame_tick", 16'(bus.frame_tick), 16'h0);

        // 1: first enable after BL edges, frame period
        rst_n = 1'b1;
        cyc1();
        check("s1_an_blank", 16'(bus.an), 16'h0);
        cyc1();
        check("s1_an_first", 16'(bus.an), 16'h1);
        check("s1_code_first", 16'(bus.code), 16'h0);
        wait_tick(w);
        check("s1_first_tick", 16'(w), 16'd29);
        wait_tick(w);
        check("s1_frame_period", 16'(w), 16'd32);

        // 2: mid-frame load, commit at the wrap
        repeat (10) cyc1();
        do_load(16'h4321);
        check("s2_pending_set", 16'(bus.pending), 16'h1);
        wait_tick(w);
        check("s2_pending_tick", 16'(bus.pending), 16'h1);
        cyc1();
        check("s2_pending_clr", 16'(bus.pending), 16'h0);
        scan_frame("s2_code", 4'd2, 4'd3, 4'd4, 4'd5);

        // 3: back-to-back loads in one frame, last wins
        wait_tick(w);
        cyc1();
        do_load(16'h0000);
        cyc1();
        cyc1();
        do_load(16'h0005);
        wait_tick(w);
        cyc1();
        scan_frame("s3_code", 4'd6, 4'd1, 4'd1, 4'd1);

        // 4: leading-zero suppression
        wait_tick(w);
        cyc1();
        do_load(16'h0070);
        bus.lz_blank = 1'b1;
        wait_tick(w);
        cyc1();
        scan_frame("s4_lz_0070", 4'd1, 4'd8, 4'd0, 4'd0);
        do_load(16'h0000);
        wait_tick(w);
        cyc1();
        scan_frame("s4_lz_0000", 4'd1, 4'd0, 4'd0, 4'd0);
        bus.lz_blank = 1'b0;
        wait_an(4'b0010);
        #1;
        check("s4_lz_off", 16'(bus.code), 16'h1);

        // 5: load on the frame_tick cycle
        wait_tick(w);
        cyc1();
        do_load(16'h1111);
        wait_tick(w);
        do_load(16'h2222);
        check("s5_pending_kept", 16'(bus.pending), 16'h1);
        wait_an(4'b0001);
        check("s5_old_commit", 16'(bus.code), 16'h2);
        wait_tick(w);
        cyc1();
        check("s5_pending_clr", 16'(bus.pending), 16'h0);
        wait_an(4'b0001);
        check("s5_new_commit", 16'(bus.code), 16'h3);

        // 6: asynchronous reset during SHOW of digit 2 with a pending load
        wait_an(4'b0100);
        do_load(16'h9876);
        check("s6_pending_set", 16'(bus.pending), 16'h1);
        check("s6_an_digit2",   16'(bus.an),      16'h4);
        #1;
        rst_n = 1'b0;
        #1;
        check("s6_rst_an",      16'(bus.an),      16'h0);
        check("s6_rst_code",    16'(bus.code),    16'h0);
        check("s6_rst_pending", 16'(bus.pending), 16'h0);
        cyc1();
        cyc1();
        rst_n = 1'b1;
        wait_tick(w);
        cyc1();
        check("s6_pending_after", 16'(bus.pending), 16'h0);
        scan_frame("s6_blank", 4'd0, 4'd0, 4'd0, 4'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got %0t expected finish before 100000", $time);
        $fatal(1);
    end
endmodule
